mdl_xxx_bram_load: RTL and testbench
====================================

// Module: mdl_xxx_bram_load
// PURPOSE
//  AXI4-Stream slave that unpacks 64-bit beats into two 32-bit coefficients and writes them to a
//  dual-port coefficient BRAM, filling PRM_COEFFS words per iFSM_START. It is the receive-side
//  counterpart of the BRAM-to-stream writer: host-to-PL DMA stream in, BRAM Port A/B writes out.
// PARAMETERS
//  PRM_DAXI    64    stream data width; must equal 2*PRM_DRAM
//  PRM_ADDR    12    BRAM address width
//  PRM_DRAM    32    BRAM word (coefficient) width
//  PRM_COEFFS  4096  coefficients per load; even, <= 2**PRM_ADDR; beats per load N = PRM_COEFFS/2
// PORTS
//  iSYS_CLK    in   1         system clock; all logic on rising edge
//  iSYS_RST    in   1         synchronous reset, active-low
//  iFSM_START  in   1         1-cycle pulse; start (or restart) a load
//  oFSM_DONE   out  1         1-cycle pulse; load complete
//  iWs_Tdata   in   PRM_DAXI  [31:0] = coeff 2k, [63:32] = coeff 2k+1
//  iWs_Tvalid  in   1         stream valid
//  iWs_Tlast   in   1         stream last (used only with MDL_LOAD_TLAST_CHK_EN)
//  oWs_Tready  out  1         stream ready (registered)
//  oB_enA/oB_weA    out 1     Port A enable / write enable
//  oB_addrA    out  PRM_ADDR  Port A address (even)
//  oB_dinA     out  PRM_DRAM  Port A write data
//  oB_enB/oB_weB    out 1     Port B enable / write enable
//  oB_addrB    out  PRM_ADDR  Port B address (odd)
//  oB_dinB     out  PRM_DRAM  Port B write data
//  oERR        out  1         sticky framing error (0 without MDL_LOAD_TLAST_CHK_EN)
// BEHAVIOUR
//  - Reset (iSYS_RST==0 at an edge): state IDLE, beat counter 0. All outputs 0.
//  - FSM: IDLE -(iFSM_START)-> LOAD -(last beat accepted)-> FLUSH -> DONE -> IDLE.
//    * LOAD: oWs_Tready=1. A beat is accepted when iWs_Tvalid & oWs_Tready. Counter advances by 1
//      per accepted beat, PRM_ADDR+1 bits wide.
//    * On the accept edge of beat N-1, oWs_Tready drops to 0. No beat N is ever accepted.
//    * FLUSH: last write strobe is on the ports.
//    * DONE: oFSM_DONE=1 for exactly one cycle, then IDLE.
//  - Write pipeline: beat k accepted in cycle t gives, in cycle t+1:
//    * oB_enA=oB_weA=oB_enB=oB_weB=1
//    * oB_addrA=2k, oB_addrB=2k+1
//    * oB_dinA=Tdata[31:0], oB_dinB=Tdata[63:32]
//    In all other cycles en/we are 0. Address and data hold their last values.
//  - Latency: last beat accepted in cycle t -> final write in t+1 -> oFSM_DONE in t+2.
//  - Tvalid low in LOAD stalls: no write, counter holds, oWs_Tready stays 1. Tdata is ignored while
//    not accepted.
//  - iFSM_START in IDLE/FLUSH/DONE: counter:=0, enter LOAD next cycle. A pending FLUSH write still
//    issues. No oFSM_DONE is produced for the aborted load.
//  - iFSM_START in LOAD: the beat accepted in that same cycle is discarded (no write strobe).
//    Counter:=0, LOAD is restarted.
//  - Reset mid-load: immediate return to IDLE. The in-flight write is dropped; BRAM contents are
//    left as-is.
//  - Addresses are counter-derived only and never wrap within a load (2N-1 <= 2**PRM_ADDR-1).
//  - Ports A and B never write the same address in one cycle.
// CONFIGURATION
//  - MDL_LOAD_TLAST_CHK_EN defined:
//    * oERR is set on an accepted beat with Tlast=1 and k<N-1, or Tlast=0 and k=N-1.
//    * The load still completes normally. oERR is sticky and is cleared by iFSM_START or reset.
//  - MDL_LOAD_TLAST_CHK_EN undefined: iWs_Tlast is ignored and oERR is tied 0.
// TESTING (PRM_COEFFS=4096, N=2048)
//  1. Reset, START, Tvalid=1 continuously, Tdata={2k+1,2k}
//     -> 2048 write pairs; BRAM[i]=i for i=0..4095; oFSM_DONE exactly 2 cycles after the last
//     accept; oWs_Tready=0 after it.
//  2. Tvalid toggled pseudo-randomly (~50%) -> identical BRAM image; write strobes only in the cycle
//     after each accept; no duplicate or skipped address.
//  3. START again after beat 100 with new data 0xA5A5_0000+i -> beat accepted in the START cycle
//     not written; writes resume at addr 0/1; a single oFSM_DONE at the end.
//  4. iSYS_RST=0 during beat 500 -> the next cycle has all outputs 0, FSM in IDLE; a following
//     START load completes correctly.
//  5. With MDL_LOAD_TLAST_CHK_EN: Tlast on beat 1000 -> oERR=1 from the cycle after that accept
//     until the next START; Tlast only on beat 2047 -> oERR stays 0.
//  6. Without the macro: random Tlast -> oERR always 0; behaviour matches test 1.

Source files
------------

// File: rtl/mdl_xxx_bram_load.sv
// Stream-to-BRAM coefficient loader: one 64-bit beat becomes two 32-bit BRAM words.
// Optional Tlast framing check enabled by defining MDL_LOAD_TLAST_CHK_EN.
//
// Ports:
//   iSYS_CLK, iSYS_RST      clock, synchronous active-low reset
//   iFSM_START, oFSM_DONE   start/restart pulse in, load-complete pulse out
//   iWs_T*, oWs_Tready      AXI4-Stream slave (data, valid, last / ready)
//   oB_*A                   BRAM Port A write side (even addresses)
//   oB_*B                   BRAM Port B write side (odd addresses)
//   oERR                    sticky framing error (tied 0 without the macro)
module mdl_xxx_bram_load #(
    parameter int PRM_DAXI   = 64,
    parameter int PRM_ADDR   = 12,
    parameter int PRM_DRAM   = 32,
    parameter int PRM_COEFFS = 4096
) (
    input  logic                iSYS_CLK,
    input  logic                iSYS_RST,
    input  logic                iFSM_START,
    output logic                oFSM_DONE,
    input  logic [PRM_DAXI-1:0] iWs_Tdata,
    input  logic                iWs_Tvalid,
    input  logic                iWs_Tlast,
    output logic                oWs_Tready,
    output logic                oB_enA,
    output logic                oB_weA,
    output logic [PRM_ADDR-1:0] oB_addrA,
    output logic [PRM_DRAM-1:0] oB_dinA,
    output logic                oB_enB,
    output logic                oB_weB,
    output logic [PRM_ADDR-1:0] oB_addrB,
    output logic [PRM_DRAM-1:0] oB_dinB,
    output logic                oERR
);

    localparam logic [PRM_ADDR:0] LAST_BEAT =
        (PRM_ADDR+1)'(PRM_COEFFS/2 - 1);
    localparam logic [PRM_ADDR:0] ONE = (PRM_ADDR+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [PRM_ADDR:0]   cnt_q, cnt_d;
    logic                rdy_q, rdy_d;
    logic                wr_q, wr_d;
    logic [PRM_ADDR-1:0] addra_q, addra_d;
    logic [PRM_ADDR-1:0] addrb_q, addrb_d;
    logic [PRM_DRAM-1:0] dina_q, dina_d;
    logic [PRM_DRAM-1:0] dinb_q, dinb_d;

    logic accept;
    logic take;
    logic last;

    // A beat arriving in the same cycle as a restart belongs to the
    // aborted load, so it is accepted but never written.
    assign accept = iWs_Tvalid & rdy_q;
    assign take   = accept & ~iFSM_START;
    assign last   = (cnt_q == LAST_BEAT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdy_d   = rdy_q;
        wr_d    = take;
        addra_d = addra_q;
        addrb_d = addrb_q;
        dina_d  = dina_q;
        dinb_d  = dinb_q;

        if (take) begin
            addra_d = {cnt_q[PRM_ADDR-2:0], 1'b0};
            addrb_d = {cnt_q[PRM_ADDR-2:0], 1'b1};
            dina_d  = iWs_Tdata[PRM_DRAM-1:0];
            dinb_d  = iWs_Tdata[PRM_DAXI-1:PRM_DRAM];
        end

        if (iFSM_START) begin
            state_d = S_LOAD;
            cnt_d   = '0;
            rdy_d   = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_LOAD: begin
                    if (take) begin
                        cnt_d = cnt_q + ONE;
                        if (last) begin
                            state_d = S_FLUSH;
                            rdy_d   = 1'b0;
                        end
                    end
                end
                S_FLUSH: begin
                    state_d = S_DONE;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    rdy_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge iSYS_CLK) begin
        if (!iSYS_RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            wr_q    <= 1'b0;
            addra_q <= '0;
            addrb_q <= '0;
            dina_q  <= '0;
            dinb_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
            wr_q    <= wr_d;
            addra_q <= addra_d;
            addrb_q <= addrb_d;
            dina_q  <= dina_d;
            dinb_q  <= dinb_d;
        end
    end

`ifdef MDL_LOAD_TLAST_CHK_EN
    logic err_q, err_d;

    // Tlast must be high exactly on the final beat of the load.
    always_comb begin
        err_d = err_q;
        if (iFSM_START) begin
            err_d = 1'b0;
        end else if (take && (iWs_Tlast != last)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge iSYS_CLK) begin
        if (!iSYS_RST) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign oERR = err_q;
`else
    logic unused_tlast;
    assign unused_tlast = iWs_Tlast;
    assign oERR         = 1'b0;
`endif

    assign oFSM_DONE  = (state_q == S_DONE);
    assign oWs_Tready = rdy_q;
    assign oB_enA     = wr_q;
    assign oB_weA     = wr_q;
    assign oB_enB     = wr_q;
    assign oB_weB     = wr_q;
    assign oB_addrA   = addra_q;
    assign oB_addrB   = addrb_q;
    assign oB_dinA    = dina_q;
    assign oB_dinB    = dinb_q;

endmodule

// File: tb/tb_mdl_xxx_bram_load.sv
// Bench for mdl_xxx_bram_load: directed loads checked against a beat-level model
// and an observed BRAM image.
module tb_mdl_xxx_bram_load;

    localparam int N = 2048;
    localparam int C = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        valid = 1'b0;
    logic        tlast = 1'b0;
    logic [63:0] tdata = '0;

    logic        done, rdy, ena, wea, enb, web, err;
    logic [11:0] addra, addrb;
    logic [31:0] dina, dinb;

    mdl_xxx_bram_load dut (
        .iSYS_CLK  (clk),
        .iSYS_RST  (rst_n),
        .iFSM_START(start),
        .oFSM_DONE (done),
        .iWs_Tdata (tdata),
        .iWs_Tvalid(valid),
        .iWs_Tlast (tlast),
        .oWs_Tready(rdy),
        .oB_enA    (ena),
        .oB_weA    (wea),
        .oB_addrA  (addra),
        .oB_dinA   (dina),
        .oB_enB    (enb),
        .oB_weB    (web),
        .oB_addrB  (addrb),
        .oB_dinB   (dinb),
        .oERR      (err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic [31:0] mem [C];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail < 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                         nm, act, exp, cyc);
        end
    endtask

    // Beat-level model: tracks readiness, beat index and the write
    // that the previous accepted beat must produce.
    bit          m_rdy, m_wr, m_flush, m_done, m_err, m_acc;
    int          m_k;
    logic [11:0] m_addra, m_addrb;
    logic [31:0] m_da, m_db;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_rdy = 0; m_wr = 0; m_flush = 0; m_done = 0; m_err = 0;
            m_k = 0; m_addra = 0; m_addrb = 0; m_da = 0; m_db = 0;
        end else begin
            m_acc  = valid && m_rdy;
            m_done = m_flush && !start;
            m_wr   = m_acc && !start;
            if (m_wr) begin
                m_addra = 12'(2 * m_k);
                m_addrb = 12'(2 * m_k + 1);
                m_da    = tdata[31:0];
                m_db    = tdata[63:32];
            end
            m_flush = 0;
            if (start) begin
                m_k = 0; m_rdy = 1; m_err = 0;
            end else if (m_acc) begin
                if (tlast != (m_k == N - 1)) m_err = 1;
                if (m_k == N - 1) begin
                    m_rdy = 0; m_flush = 1;
                end else begin
                    m_k++;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("tready", rdy, m_rdy);
        chk("enA", ena, m_wr);
        chk("weA", wea, m_wr);
        chk("enB", enb, m_wr);
        chk("weB", web, m_wr);
        chk("addrA", addra, m_addra);
        chk("addrB", addrb, m_addrb);
        chk("dinA", dina, m_da);
        chk("dinB", dinb, m_db);
        chk("done", done, m_done);
`ifdef MDL_LOAD_TLAST_CHK_EN
        chk("err", err, m_err);
`else
        chk("err", err, 0);
`endif
        if (wea) mem[addra] = dina;
        if (web) mem[addrb] = dinb;
        if (done) done_cnt++;
    end

    task automatic clear_mem();
        for (int i = 0; i < C; i++) mem[i] = 'x;
    endtask

    task automatic img(input string nm, input logic [31:0] base);
        int bad = 0;
        for (int i = 0; i < C; i++)
            if (mem[i] !== base + 32'(i)) bad++;
        chk(nm, bad, 0);
    endtask

    task automatic load(input bit do_start, input int pct,
                        input logic [31:0] base, input int stop_at,
                        input int tl_beat, input bit rnd_last,
                        output int lat);
        int idx = 0;
        int guard = 0;
        int last_cyc = 0;
        bit seen = 0;
        logic r;
        logic [31:0] c0;
        lat = -1;
        if (do_start) begin
            @(negedge clk);
            start = 1; valid = 0;
        end
        while (idx < stop_at && guard < 20000) begin
            @(negedge clk);
            start = 0;
            guard++;
            r = rdy;
            valid = ($urandom_range(99) < pct);
            c0 = base + 32'(2 * idx);
            tdata = {c0 + 32'd1, c0};
            tlast = rnd_last ? 1'($urandom_range(1)) : (idx == tl_beat);
            if (valid && r) begin
                idx++;
                last_cyc = cyc;
            end
        end
        if (idx < stop_at) chk("load_timeout", idx, stop_at);
        if (stop_at == N) begin
            for (int w = 0; w < 8 && !seen; w++) begin
                @(negedge clk);
                valid = 0; tlast = 0;
                if (done) begin
                    seen = 1;
                    lat = cyc - last_cyc;
                end
            end
            chk("done_seen", seen, 1);
        end
    endtask

    int lat;
    int d0;

    initial begin
        clear_mem();
        repeat (3) @(negedge clk);
        chk("rst_tready", rdy, 0);
        chk("rst_addrB", addrb, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst_n = 1;

        // 1: continuous stream
        @(posedge clk); d0 = done_cnt;
        load(1, 100, 0, N, N - 1, 0, lat);
        @(posedge clk);
        chk("t1_latency", lat, 2);
        chk("t1_done_cnt", done_cnt - d0, 1);
        chk("t1_tready_after", rdy, 0);
        chk("t1_addrA_last", addra, 4094);
        chk("t1_dinB_last", dinb, 4095);
        chk("t1_mem4095", mem[4095], 4095);
        img("t1_image", 0);

        // 2: gappy valid
        clear_mem();
        @(posedge clk); d0 = done_cnt;
        load(1, 50, 0, N, N - 1, 0, lat);
        @(posedge clk);
        chk("t2_latency", lat, 2);
        chk("t2_done_cnt", done_cnt - d0, 1);
        img("t2_image", 0);

        // 3: restart after beat 100
        clear_mem();
        @(posedge clk); d0 = done_cnt;
        load(1, 100, 0, 101, N - 1, 0, lat);
        @(negedge clk);
        start = 1; valid = 1; tdata = 64'hDEAD_BEEF_DEAD_BEEF;
        load(0, 100, 32'hA5A5_0000, N, N - 1, 0, lat);
        @(posedge clk);
        chk("t3_latency", lat, 2);
        chk("t3_done_cnt", done_cnt - d0, 1);
        chk("t3_mem0", mem[0], 32'hA5A5_0000);
        img("t3_image", 32'hA5A5_0000);

        // 4: reset during beat 500
        clear_mem();
        load(1, 100, 0, 500, N - 1, 0, lat);
        @(negedge clk);
        rst_n = 0; valid = 1; tdata = 64'h1234_5678_9ABC_DEF0;
        @(negedge clk);
        chk("t4_rst_tready", rdy, 0);
        chk("t4_rst_enA", ena, 0);
        chk("t4_rst_addrB", addrb, 0);
        chk("t4_rst_dinB", dinb, 0);
        chk("t4_mem998", mem[998], 998);
        chk("t4_mem1000", mem[1000], 'x);
        rst_n = 1; valid = 0;
        clear_mem();
        @(posedge clk); d0 = done_cnt;
        load(1, 100, 32'h1111_0000, N, N - 1, 0, lat);
        @(posedge clk);
        chk("t4_latency", lat, 2);
        chk("t4_done_cnt", done_cnt - d0, 1);
        img("t4_image", 32'h1111_0000);

`ifdef MDL_LOAD_TLAST_CHK_EN
        // 5: framing check
        load(1, 100, 0, N, 1000, 0, lat);
        chk("t5_err_set", err, 1);
        chk("t5_latency", lat, 2);
        load(1, 100, 0, N, N - 1, 0, lat);
        chk("t5_err_clear", err, 0);
`else
        // 6: Tlast ignored
        clear_mem();
        load(1, 100, 0, N, 0, 1, lat);
        chk("t6_err", err, 0);
        chk("t6_latency", lat, 2);
        img("t6_image", 0);
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
